// File: rtl/crypt_pkg.sv
// Shared types and sizes for the encryptor-to-USB byte serializer.
package crypt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    SEND = 2'd2
  } state_e;

  localparam int BLOCK_W         = 64;
  localparam int BYTE_W          = 8;
  localparam int BYTES_PER_BLOCK = 8;
  localparam int IDX_W           = 3;

endpackage

// File: rtl/byte_mux_64to8.sv
// Selects one byte of a 64-bit block; LSB_FIRST chooses which end is byte 0.
module byte_mux_64to8
  import crypt_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic [BLOCK_W-1:0] block_i,
  input  logic [IDX_W-1:0]   idx_i,
  output logic [BYTE_W-1:0]  byte_o
);

  logic [IDX_W-1:0] sel;

  always_comb begin
    // Inverting a 3-bit index gives 7-idx, i.e. MSB-first ordering.
    sel    = LSB_FIRST ? idx_i : ~idx_i;
    byte_o = block_i[sel*BYTE_W +: BYTE_W];
  end

endmodule

// File: rtl/crypt_tx_serializer.sv
// Captures 64-bit blocks from the encryptor core, acknowledges them and
// streams each block as 8 bytes over a valid/ready interface.
module crypt_tx_serializer
  import crypt_pkg::*;
#(
  parameter int ACK_CYCLES = 2,
  parameter bit LSB_FIRST  = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BLOCK_W-1:0] trans_data,
  input  logic               trans_data_ready,
  output logic               handshake_ack,
  output logic [BYTE_W-1:0]  tx_byte,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               tx_last,
  output logic               busy,
  output logic [CNT_W-1:0]   blocks_sent
);

  localparam logic [IDX_W-1:0] ACK_LAST = IDX_W'(ACK_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_BLOCK - 1);

  state_e             state_q, state_d;
  logic [BLOCK_W-1:0] hold_q, hold_d;
  logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic [IDX_W-1:0]   ack_cnt_q, ack_cnt_d;
  logic               armed_q, armed_d;
  logic               ack_q, ack_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BYTE_W-1:0]  mux_byte;

  byte_mux_64to8 #(
    .LSB_FIRST(LSB_FIRST)
  ) u_byte_mux (
    .block_i(hold_q),
    .idx_i  (byte_idx_q),
    .byte_o (mux_byte)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      byte_idx_q <= '0;
      ack_cnt_q  <= '0;
      armed_q    <= 1'b1;
      ack_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      byte_idx_q <= byte_idx_d;
      ack_cnt_q  <= ack_cnt_d;
      armed_q    <= armed_d;
      ack_q      <= ack_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    byte_idx_d = byte_idx_q;
    ack_cnt_d  = ack_cnt_q;
    armed_d    = armed_q;
    ack_d      = ack_q;
    cnt_d      = cnt_q;

    // Re-arm only once the core has dropped its level flag, so a block it
    // still holds high is never captured twice.
    if (!trans_data_ready) begin
      armed_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (trans_data_ready && armed_q) begin
          hold_d     = trans_data;
          armed_d    = 1'b0;
          ack_cnt_d  = '0;
          byte_idx_d = '0;
          ack_d      = 1'b1;
          state_d    = ACK;
        end
      end
      ACK: begin
        ack_cnt_d = ack_cnt_q + 3'd1;
        if (ack_cnt_q == ACK_LAST) begin
          ack_d   = 1'b0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          byte_idx_d = byte_idx_q + 3'd1;
          if (byte_idx_q == LAST_IDX) begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_valid      = (state_q == SEND);
    tx_byte       = tx_valid ? mux_byte : '0;
    tx_last       = tx_valid && (byte_idx_q == LAST_IDX);
    busy          = (state_q != IDLE);
    handshake_ack = ack_q;
    blocks_sent   = cnt_q;
  end

endmodule

// File: doc/crypt_tx_serializer.md
Name: crypt_tx_serializer

Overview:
- Consumer end of the encryptor core's output handshake.
- Captures each 64-bit block presented on trans_data/trans_data_ready and returns handshake_ack to the core.
- Streams the captured block as 8 bytes over a valid/ready byte interface to the USB transmit path.
- Sits between encryptor_core and the USB TX packetizer.

Parameters:
- ACK_CYCLES, 2, number of consecutive cycles handshake_ack is held high per captured block (1..7).
- LSB_FIRST, 1, 1 = byte 0 is trans_data[7:0]; 0 = byte 0 is trans_data[63:56].
- CNT_W, 16, width of the blocks_sent counter.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- trans_data  in  64  block from encryptor core; valid while trans_data_ready=1.
- trans_data_ready  in  1  block-available flag; level, held by core until acknowledged.
- handshake_ack  out  1  acknowledge to core; high for ACK_CYCLES cycles after capture.
- tx_byte  out  8  current output byte.
- tx_valid  out  1  tx_byte valid.
- tx_ready  in  1  downstream accepts; a transfer occurs on a cycle with tx_valid & tx_ready.
- tx_last  out  1  high with the 8th byte of a block.
- busy  out  1  high in any state other than IDLE.
- blocks_sent  out  CNT_W  count of fully transmitted blocks; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; handshake_ack, tx_valid, tx_last, busy = 0.
  - tx_byte, blocks_sent, holding register, byte_idx, ack_cnt = 0.
  - armed=1.
  - Reset mid-operation aborts the block; it is discarded, never partially resent.
- armed flag:
  - Cleared on capture.
  - Set on any cycle where trans_data_ready=0.
  - Prevents re-capturing a block the core still holds high.
- IDLE: if trans_data_ready & armed:
  - hold_reg <= trans_data, armed <= 0, ack_cnt <= 0, byte_idx <= 0.
  - Go to ACK.
  - Capture latency 1 cycle.
- ACK:
  - handshake_ack=1 (registered), held exactly ACK_CYCLES cycles, starting the cycle after capture.
  - ack_cnt increments each cycle; at ack_cnt==ACK_CYCLES-1, go to SEND.
  - tx_valid=0 throughout ACK.
- SEND:
  - tx_valid=1.
  - tx_byte = hold_reg byte[byte_idx], with byte ordering per LSB_FIRST.
  - tx_last = (byte_idx==7).
  - On a transfer: byte_idx++.
  - On a transfer with byte_idx==7: blocks_sent++ and go to IDLE. tx_valid drops the next cycle.
  - tx_byte and tx_last are stable while tx_valid & !tx_ready (AXI-style hold); no byte is skipped or repeated.
  - Trans_data changes during ACK or SEND have no effect; only hold_reg is used.
- First byte is presented ACK_CYCLES+1 cycles after the capture edge.
- Minimum block period (tx_ready=1 always): 1 + ACK_CYCLES + 8 cycles.
- Back-to-back blocks: the next capture is allowed in the IDLE cycle immediately after the last transfer, provided armed=1.
- Simultaneous events:
  - If trans_data_ready falls in the same cycle the last byte transfers, armed is set; the next rise is captured normally.
  - rst has priority over every transition.
- busy=1 in ACK and SEND.
- tx_byte is 0 whenever tx_valid=0.

Decomposition:
- Shared package crypt_pkg:
  - state enum {IDLE, ACK, SEND}.
  - BLOCK_W=64, BYTE_W=8, BYTES_PER_BLOCK=8.
- One sub-module, byte_mux_64to8:
  - Combinational byte select from hold_reg and byte_idx, honouring LSB_FIRST.
- FSM, counters and handshake stay in the top module.

Test Plan:
1. Basic block, tx_ready=1:
   - Stimulus: trans_data=64'hb533f124beb485ec, ready raised.
   - Response: handshake_ack high for cycles +1..+2.
   - Bytes ec,85,b4,be,24,f1,33,b5 on consecutive cycles starting at +3; tx_last only on b5.
   - blocks_sent=1.
2. Backpressure:
   - Stimulus: same block, tx_ready toggled 1,0,0,1,0,1...
   - Response: the 8 bytes arrive in order, each held stable while stalled; no duplicates; blocks_sent=1.
3. Level-held ready:
   - Stimulus: trans_data_ready held high for 30 cycles with 64'h6ca7c3f173252118.
   - Response: exactly one capture and one 8-byte burst, starting 18,a7? no: ordered 18,21,25,73,f1,c3,a7,6c.
   - After ready drops then rises with 64'h9999999999999999: eight 8'h99 bytes; blocks_sent=2.
4. Reset mid-SEND:
   - Stimulus: rst pulsed after 3 bytes transferred.
   - Response: all outputs 0 the next cycle, blocks_sent=0.
   - A new block sends its full 8 bytes from byte 0.
5. LSB_FIRST=0, ACK_CYCLES=1:
   - Stimulus: 64'h675A69675E5A6B5A.
   - Response: ack high 1 cycle; bytes 67,5a,69,67,5e,5a,6b,5a starting at capture+2.
6. Counter wrap, CNT_W=2:
   - Stimulus: 5 blocks.
   - Response: blocks_sent sequence 1,2,3,0,1.
